mac_cluster_param: RTL

//  Parametrised successor of the fixed 3-image x 16-neuron quantised MAC cluster for the MNIST FPGA datapath.

---
 rtl/mac_cluster_pkg.sv | 50 +++++
 rtl/mac_cluster_param_lane.sv | 43 ++++
 rtl/mac_cluster_param.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mac_cluster_pkg.sv
// rtl/mac_cluster_pkg.sv - shared state encoding and arithmetic helpers for mac_cluster_param
package mac_cluster_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACCUM = 2'b01,
      DRAIN = 2'b10
   } state_e;

   localparam logic [1:0] STATUS_IDLE  = 2'b00;
   localparam logic [1:0] STATUS_ACCUM = 2'b01;
   localparam logic [1:0] STATUS_DRAIN = 2'b10;

   // Arithmetic is done at 64 bits so one helper serves every parameterisation.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                  input logic signed [63:0] prod,
                                                  input int acc_bits);
      logic signed [63:0] sum, hi, lo;
      sum = acc + prod;
      hi  = (64'sd1 <<< (acc_bits - 1)) - 64'sd1;
      lo  = -hi - 64'sd1;
      if (sum > hi)
         sat_add = hi;
      else if (sum < lo)
         sat_add = lo;
      else
         sat_add = sum;
   endfunction

   function automatic logic [31:0] quant_out(input logic signed [63:0] acc,
                                             input logic relu,
                                             input int out_shift,
                                             input int a_bits);
      logic signed [63:0] s, hi, lo;
      s = acc >>> out_shift;
      if (relu) begin
         hi = (64'sd1 <<< a_bits) - 64'sd1;
         lo = 64'sd0;
      end else begin
         hi = (64'sd1 <<< (a_bits - 1)) - 64'sd1;
         lo = -hi - 64'sd1;
      end
      if (s > hi)
         s = hi;
      else if (s < lo)
         s = lo;
      quant_out = s[31:0];
   endfunction

endpackage

// File: rtl/mac_cluster_param_lane.sv
// rtl/mac_cluster_param_lane.sv - mac_lane: one saturating signed MAC accumulator with bias load
module mac_lane
   import mac_cluster_pkg::*;
#(
   parameter int X_BITS   = 4,
   parameter int W_BITS   = 4,
   parameter int B_BITS   = 4,
   parameter int ACC_BITS = 18,
   parameter int B_SHIFT  = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       load,
   input  logic                       en,
   input  logic signed [B_BITS-1:0]   bias,
   input  logic        [X_BITS-1:0]   x,
   input  logic signed [W_BITS-1:0]   w,
   output logic signed [ACC_BITS-1:0] acc
);

   logic signed [ACC_BITS-1:0] acc_q, acc_d;
   logic signed [63:0]         prod;

   always_comb begin
      // x is unsigned, so it gets a zero sign bit before the signed multiply.
      prod  = $signed(64'({1'b0, x})) * 64'(w);
      acc_d = acc_q;
      if (load)
         acc_d = ACC_BITS'(64'(bias) <<< B_SHIFT);
      else if (en)
         acc_d = ACC_BITS'(sat_add(64'(acc_q), prod, ACC_BITS));
   end

   always_ff @(posedge CLK) begin
      if (RST)
         acc_q <= '0;
      else
         acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/mac_cluster_param.sv
// rtl/mac_cluster_param.sv - N_IMG x N_NEU quantised MAC cluster with AXI-S activation output
// Optional a_tlast output enabled by defining MAC_CLUSTER_TLAST_EN.
module mac_cluster_param
   import mac_cluster_pkg::*;
#(
   parameter int IN_SIZE   = 784,
   parameter int N_IMG     = 3,
   parameter int N_NEU     = 16,
   parameter int X_BITS    = 4,
   parameter int W_BITS    = 4,
   parameter int B_BITS    = 4,
   parameter int ACC_BITS  = 18,
   parameter int B_SHIFT   = 4,
   parameter int OUT_SHIFT = 7,
   parameter int A_BITS    = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [N_IMG*X_BITS-1:0]   x_tdata,
   input  logic                      x_tvalid,
   output logic                      x_tready,
   input  logic [N_NEU*W_BITS-1:0]   w_tdata,
   input  logic                      w_tvalid,
   output logic                      w_tready,
   input  logic [N_NEU*B_BITS-1:0]   b_tdata,
   input  logic                      b_tvalid,
   output logic                      b_tready,
   output logic [A_BITS-1:0]         a_tdata,
   output logic                      a_tvalid,
   input  logic                      a_tready,
   input  logic                      cfg_relu,
`ifdef MAC_CLUSTER_TLAST_EN
   output logic                      a_tlast,
`endif
   output logic [1:0]                status
);

   localparam int NK    = N_NEU * N_IMG;
   localparam int KW    = $clog2(NK > 1 ? NK : 2);
   localparam int CW    = $clog2(IN_SIZE > 1 ? IN_SIZE : 2);
   localparam logic [KW-1:0] LAST_K    = KW'(NK - 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(IN_SIZE - 1);

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [KW-1:0]     k_q, k_d, sel;
   logic              relu_q, relu_d;
   logic              a_tvalid_q, a_tvalid_d;
   logic [A_BITS-1:0] a_tdata_q, a_tdata_d;
   logic [1:0]        status_q, status_d;
   logic              b_fire, beat, drain_adv, drain_done, drain_load;

   logic signed [ACC_BITS-1:0] acc_arr [NK];

   // Each stream's ready waits on the other's valid so a beat is only ever taken jointly.
   assign b_tready = !RST && (state_q == IDLE);
   assign x_tready = !RST && (state_q == ACCUM) && w_tvalid;
   assign w_tready = !RST && (state_q == ACCUM) && x_tvalid;
   assign b_fire   = b_tready && b_tvalid;
   assign beat     = !RST && (state_q == ACCUM) && x_tvalid && w_tvalid;

   assign drain_adv  = (state_q == DRAIN) && (!a_tvalid_q || a_tready);
   assign drain_done = drain_adv && a_tvalid_q && (k_q == LAST_K);
   assign drain_load = drain_adv && !drain_done;
   assign sel        = a_tvalid_q ? k_q + 1'b1 : k_q;

   for (genvar n = 0; n < N_NEU; n++) begin : g_neu
      for (genvar i = 0; i < N_IMG; i++) begin : g_img
         mac_lane #(
            .X_BITS  (X_BITS),
            .W_BITS  (W_BITS),
            .B_BITS  (B_BITS),
            .ACC_BITS(ACC_BITS),
            .B_SHIFT (B_SHIFT)
         ) u_lane (
            .CLK (CLK),
            .RST (RST),
            .load(b_fire),
            .en  (beat),
            .bias(b_tdata[n*B_BITS +: B_BITS]),
            .x   (x_tdata[i*X_BITS +: X_BITS]),
            .w   (w_tdata[n*W_BITS +: W_BITS]),
            .acc (acc_arr[n*N_IMG + i])
         );
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      k_d        = k_q;
      relu_d     = relu_q;
      a_tvalid_d = a_tvalid_q;
      a_tdata_d  = a_tdata_q;
      case (state_q)
         IDLE: begin
            if (b_fire) begin
               relu_d  = cfg_relu;
               cnt_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (beat) begin
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  k_d     = '0;
                  state_d = DRAIN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (drain_done) begin
               a_tvalid_d = 1'b0;
               k_d        = '0;
               state_d    = IDLE;
            end else if (drain_load) begin
               k_d        = sel;
               a_tvalid_d = 1'b1;
               a_tdata_d  = A_BITS'(quant_out(64'(acc_arr[sel]), relu_q, OUT_SHIFT, A_BITS));
            end
         end
         default: state_d = IDLE;
      endcase
      case (state_d)
         ACCUM:   status_d = STATUS_ACCUM;
         DRAIN:   status_d = STATUS_DRAIN;
         default: status_d = STATUS_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         k_q        <= '0;
         relu_q     <= 1'b0;
         a_tvalid_q <= 1'b0;
         a_tdata_q  <= '0;
         status_q   <= STATUS_IDLE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         k_q        <= k_d;
         relu_q     <= relu_d;
         a_tvalid_q <= a_tvalid_d;
         a_tdata_q  <= a_tdata_d;
         status_q   <= status_d;
      end
   end

   assign a_tdata  = a_tdata_q;
   assign a_tvalid = a_tvalid_q;
   assign status   = status_q;

`ifdef MAC_CLUSTER_TLAST_EN
   logic a_tlast_q, a_tlast_d;

   always_comb begin
      a_tlast_d = a_tlast_q;
      if (drain_done)
         a_tlast_d = 1'b0;
      else if (drain_load)
         a_tlast_d = (sel == LAST_K);
   end

   always_ff @(posedge CLK) begin
      if (RST)
         a_tlast_q <= 1'b0;
      else
         a_tlast_q <= a_tlast_d;
   end

   assign a_tlast = a_tlast_q;
`endif

endmodule
